// File: rtl/ripple_counter_mod5_down.sv
// ripple_counter_mod5_down
// 3-bit modulo-5 down counter: 0 -> 4 -> 3 -> 2 -> 1 -> 0 -> 4 ...
// Advances once per rising clk edge. An active-high asynchronous reset forces
// the count to 0. Corrupted states (5, 6, 7) recover to 4 on the next edge.
// The counter is built synchronously, so out only changes at a rising clk
// edge or on reset assertion and never shows a transient illegal value.
`timescale 1ns/100ps
module ripple_counter_mod5_down (
    output logic [2:0] out,
    input  logic       clk,
    input  logic       reset
);

    logic [2:0] count_q;
    logic [2:0] count_d;

    // Next-count decode: step down by one, wrap 0 to 4, send any illegal code to 4
    always_comb begin
        count_d = 3'd4;
        case (count_q)
            3'd0:    count_d = 3'd4;
            3'd4:    count_d = 3'd3;
            3'd3:    count_d = 3'd2;
            3'd2:    count_d = 3'd1;
            3'd1:    count_d = 3'd0;
            default: count_d = 3'd4;
        endcase
    end

    // Count register with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out = count_q;

endmodule

// File: tb/tb_ripple_counter_mod5_down.sv
// Bench for ripple_counter_mod5_down: directed power-up, free run, async reset,
// held reset and corrupted-state recovery, followed by randomized run lengths
// and reset pulses, all compared against an arithmetic model of the count.
`timescale 1ns/100ps
module tb_ripple_counter_mod5_down;

    logic       clk;
    logic       reset;
    logic [2:0] out;

    int checks   = 0;
    int failures = 0;

    // Reference model: the count as a plain integer 0..4
    int  model_n        = 0;
    bit  illegal_pending = 1'b0;
    bit  corrupt        = 1'b0;

    logic [2:0] exp_q[$];

    ripple_counter_mod5_down dut (
        .out   (out),
        .clk   (clk),
        .reset (reset)
    );

    // Clock: period 2, rising edges at t = 1, 3, 5, ...
    initial begin
        clk = 1'b0;
        forever #1 clk = ~clk;
    end

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One rising edge: update the model from the counting rules, then sample
    task automatic tick(input string tag);
        @(posedge clk);
        if (reset) begin
            model_n = 0;
        end else if (illegal_pending) begin
            model_n = 4;
            illegal_pending = 1'b0;
        end else begin
            model_n = (model_n + 4) % 5;
        end
        #0.5;
        check(tag, out, 3'(model_n));
    endtask

    // Reset pulse asserted in the low clock phase, held across hold_edges edges
    task automatic pulse_reset(input int hold_edges);
        @(negedge clk);
        #0.3;
        reset = 1'b1;
        model_n = 0;
        #0.1;
        check("async_reset_assert", out, 3'd0);
        if (hold_edges == 0) begin
            #0.2;
        end else begin
            repeat (hold_edges) tick("reset_held");
            @(negedge clk);
            #0.3;
        end
        reset = 1'b0;
        #0.1;
        check("reset_released_no_edge", out, 3'd0);
    endtask

    // Corrupt the state register in the low phase, then let one edge recover it
    task automatic inject(input int sel);
        logic [2:0] bad;
        @(negedge clk);
        #0.3;
        corrupt = 1'b1;
        case (sel)
            0:       begin force dut.count_q = 3'b111; bad = 3'b111; end
            1:       begin force dut.count_q = 3'b101; bad = 3'b101; end
            default: begin force dut.count_q = 3'b110; bad = 3'b110; end
        endcase
        #0.1;
        release dut.count_q;
        #0.1;
        check("corrupt_visible", out, bad);
        illegal_pending = 1'b1;
        tick("illegal_recover");
        corrupt = 1'b0;
        tick("after_recover_1");
        tick("after_recover_2");
    endtask

    // Monitor: out must not change across a falling clk edge
    always @(negedge clk) begin
        logic [2:0] pre;
        pre = out;
        #0.2;
        if (!corrupt) begin
            checks++;
            assert (out === pre) else begin
                failures++;
                $error("FAIL negedge_stable observed=%b expected=%b", out, pre);
            end
        end
    end

    // Monitor: settled out in the high phase must be a legal code
    always @(posedge clk) begin
        #0.7;
        if (!corrupt) begin
            checks++;
            assert (out <= 3'd4) else begin
                failures++;
                $error("FAIL legal_code observed=%b expected=<=100", out);
            end
        end
    end

    initial begin
        reset = 1'b1;
        exp_q = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4};

        // Power-up: out stays 0 through t < 5, including the edge at t = 3.
        // Release lands just after that edge so the edge itself sees reset high.
        #0.5 check("powerup_t0", out, 3'd0);
        #1   check("powerup_t1", out, 3'd0);
        #1   check("powerup_t2", out, 3'd0);
        @(posedge clk);
        #0.1 reset = 1'b0;
        model_n = 0;
        #0.4 check("release_edge_t3", out, 3'd0);
        #1   check("powerup_t4", out, 3'd0);

        // Free run from t = 5 to t = 40 against the written-out sequence and the model
        for (int i = 0; i < 18; i++) begin
            tick("free_run");
            if (exp_q.size() > 0) begin
                logic [2:0] e;
                e = exp_q.pop_front();
                check("free_run_sequence", out, e);
            end
        end

        // Async reset mid-count with out = 011
        for (int i = 0; i < 6; i++) begin
            if (model_n == 3) break;
            tick("seek_011");
        end
        check("at_011", out, 3'd3);
        pulse_reset(0);
        tick("first_after_async");

        // Reset held across several edges
        tick("pre_hold");
        pulse_reset(3);
        tick("first_after_hold");
        tick("second_after_hold");

        // Corrupted-state recovery
        inject(0);
        inject(1);
        inject(2);

        // Randomized run lengths and reset pulses
        for (int k = 0; k < 10; k++) begin
            int n;
            n = $urandom_range(1, 7);
            for (int j = 0; j < n; j++) tick("rand_run");
            if ($urandom_range(0, 1) == 1) begin
                pulse_reset($urandom_range(0, 3));
                tick("rand_after_reset");
            end
        end
        tick("final");

        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
